coeff_mux_pipe: RTL

//  Parametrised NUM_IN:1 coefficient selector for the RLWE datapath.

---
 rtl/coeff_mux_pipe_if.sv | 30 +++
 rtl/coeff_mux_pipe.sv | 91 +++++++++
 2 files changed

// File: rtl/coeff_mux_pipe_if.sv
// rtl/coeff_mux_pipe_if.sv - handshake bundle for the coefficient selector pipeline
interface coeff_mux_pipe_if #(
   parameter int WIDTH  = 30,
   parameter int NUM_IN = 16,
   parameter int SEL_W  = 4
);
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]        sel;
   logic                    auto_en;
   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_sel;
   logic                    out_valid;
   logic                    out_ready;
   logic                    sel_err;
   logic                    err_clr;

   // upstream source / downstream sink side
   modport master (
      output in_data, sel, auto_en, in_valid, out_ready, err_clr,
      input  in_ready, out_data, out_sel, out_valid, sel_err
   );

   // the selector pipeline itself
   modport slave (
      input  in_data, sel, auto_en, in_valid, out_ready, err_clr,
      output in_ready, out_data, out_sel, out_valid, sel_err
   );
endinterface

// File: rtl/coeff_mux_pipe.sv
// rtl/coeff_mux_pipe.sv - NUM_IN:1 coefficient selector with round-robin gather and registered pipeline
module coeff_mux_pipe #(
   parameter int WIDTH  = 30,
   parameter int NUM_IN = 16,
   parameter int SEL_W  = 4,
   parameter int STAGES = 2
) (
   input logic             clk,
   input logic             rst,
   coeff_mux_pipe_if.slave bus
);
   logic [WIDTH-1:0] st_data [STAGES];
   logic [SEL_W-1:0] st_sel  [STAGES];
   logic             st_vld  [STAGES];

   logic [SEL_W-1:0] rr_cnt;
   logic [SEL_W-1:0] idx;
   logic [WIDTH-1:0] mux_data;
   logic             idx_ok;
   logic             en;
   logic             accept;
   logic             sel_err_q;

   // the whole pipe moves as one: any free slot at the head lets every stage shift
   assign en     = bus.out_ready | ~st_vld[STAGES-1];
   assign accept = bus.in_valid & en;
   assign idx    = bus.auto_en ? rr_cnt : bus.sel;
   assign idx_ok = (int'(idx) < NUM_IN);

   // channel mux ahead of stage 1; indices with no channel fall through to zero
   always_comb begin
      mux_data = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (idx == SEL_W'(k)) begin
            mux_data = bus.in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // pipeline stages: stage 0 captures the selected beat, later stages copy forward
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < STAGES; s++) begin
            st_data[s] <= '0;
            st_sel[s]  <= '0;
            st_vld[s]  <= 1'b0;
         end
      end else if (en) begin
         st_data[0] <= mux_data;
         st_sel[0]  <= idx;
         st_vld[0]  <= bus.in_valid;
         for (int s = 1; s < STAGES; s++) begin
            st_data[s] <= st_data[s-1];
            st_sel[s]  <= st_sel[s-1];
            st_vld[s]  <= st_vld[s-1];
         end
      end
   end

   // round-robin pointer: restarts at channel 0 whenever auto mode is off
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_cnt <= '0;
      end else if (!bus.auto_en) begin
         rr_cnt <= '0;
      end else if (accept) begin
         if (rr_cnt == SEL_W'(NUM_IN - 1)) begin
            rr_cnt <= '0;
         end else begin
            rr_cnt <= rr_cnt + 1'b1;
         end
      end
   end

   // sticky out-of-range flag; a new bad accept beats a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_err_q <= 1'b0;
      end else if (accept && !idx_ok) begin
         sel_err_q <= 1'b1;
      end else if (bus.err_clr) begin
         sel_err_q <= 1'b0;
      end
   end

   assign bus.in_ready  = en;
   assign bus.out_data  = st_data[STAGES-1];
   assign bus.out_sel   = st_sel[STAGES-1];
   assign bus.out_valid = st_vld[STAGES-1];
   assign bus.sel_err   = sel_err_q;
endmodule
